// File: rtl/imem_load_responder.sv
// ----------------------------------------------------------------------------
// imem_load_responder
//
// Instruction memory that sits between the program loader and the fetch stage.
// The loader writes a word by raising ld_write. Only the rising edge of the
// strobe captures a word. Each capture stores ld_data at ld_addr, sets the
// slot-valid bit and pulses ld_ack. The fetch port is registered and has one
// cycle of latency. A slot that has never been written reads as NOP_WORD.
//
// Parameters
//   AW        address width; depth is 2**AW words
//   DW        instruction width
//   NOP_WORD  word returned for slots that are not loaded
//
// Ports
//   clk          in   1     system clock, rising edge
//   reset        in   1     asynchronous, active-high reset
//   ld_write     in   1     load strobe; a word is captured on its 0->1 edge
//   ld_addr      in   AW    load address, sampled with ld_write
//   ld_data      in   DW    load data, sampled with ld_write
//   ld_ack       out  1     one-cycle pulse, the cycle after a capture
//   ld_count     out  AW+1  number of distinct slots written since reset
//   fetch_en     in   1     fetch request this cycle
//   fetch_pc     in   AW    word address to fetch
//   fetch_instr  out  DW    fetched word, valid when fetch_valid=1
//   fetch_valid  out  1     one-cycle pulse, the cycle after fetch_en
//   fetch_loaded out  1     the fetched slot had been written
// ----------------------------------------------------------------------------
module imem_load_responder #(
   parameter int unsigned   AW       = 6,
   parameter int unsigned   DW       = 32,
   parameter logic [DW-1:0] NOP_WORD = DW'(32'h6800_0000)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_write,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ack,
   output logic [AW:0]   ld_count,
   input  logic          fetch_en,
   input  logic [AW-1:0] fetch_pc,
   output logic [DW-1:0] fetch_instr,
   output logic          fetch_valid,
   output logic          fetch_loaded
);

   localparam int unsigned DEPTH     = 2 ** AW;
   localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0] COUNT_ONE = (AW+1)'(1);

   // Program storage. It has no reset; the valid bits hide stale contents.
   logic [DW-1:0]    mem_q [DEPTH];

   // Control and output state
   logic [DEPTH-1:0] valid_q,        valid_d;
   logic             ld_write_q;
   logic             ld_ack_q;
   logic [AW:0]      ld_count_q,     ld_count_d;
   logic [DW-1:0]    fetch_instr_q,  fetch_instr_d;
   logic             fetch_valid_q;
   logic             fetch_loaded_q, fetch_loaded_d;

   // Combinational helpers
   logic             capture_c;
   logic             new_slot_c;
   logic             fwd_c;

   // Next-state logic for the load and fetch paths
   always_comb begin
      capture_c      = 1'b0;
      new_slot_c     = 1'b0;
      fwd_c          = 1'b0;
      valid_d        = valid_q;
      ld_count_d     = ld_count_q;
      fetch_instr_d  = fetch_instr_q;
      fetch_loaded_d = fetch_loaded_q;

      // ld_write_q comes out of reset high. A strobe that is already high
      // when reset is released therefore does not count as an edge.
      capture_c  = ld_write & ~ld_write_q;
      new_slot_c = ~valid_q[ld_addr];

      if (capture_c) begin
         valid_d[ld_addr] = 1'b1;
         // Only first writes to a slot increment the count. The saturation
         // guard is a backstop; the count cannot normally exceed DEPTH.
         if (new_slot_c && (ld_count_q != COUNT_MAX)) begin
            ld_count_d = ld_count_q + COUNT_ONE;
         end
      end

      // A capture and a fetch to the same slot in the same cycle forward the
      // incoming word, so the fetch sees the new data (write-first).
      fwd_c = capture_c && (ld_addr == fetch_pc);

      if (fetch_en) begin
         if (fwd_c) begin
            fetch_instr_d  = ld_data;
            fetch_loaded_d = 1'b1;
         end else if (valid_q[fetch_pc]) begin
            fetch_instr_d  = mem_q[fetch_pc];
            fetch_loaded_d = 1'b1;
         end else begin
            fetch_instr_d  = NOP_WORD;
            fetch_loaded_d = 1'b0;
         end
      end
   end

   // Control registers. Reset drops any capture or fetch that is in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q        <= '0;
         ld_write_q     <= 1'b1;
         ld_ack_q       <= 1'b0;
         ld_count_q     <= '0;
         fetch_instr_q  <= NOP_WORD;
         fetch_valid_q  <= 1'b0;
         fetch_loaded_q <= 1'b0;
      end else begin
         valid_q        <= valid_d;
         ld_write_q     <= ld_write;
         ld_ack_q       <= capture_c;
         ld_count_q     <= ld_count_d;
         fetch_instr_q  <= fetch_instr_d;
         fetch_valid_q  <= fetch_en;
         fetch_loaded_q <= fetch_loaded_d;
      end
   end

   // Storage write port. capture_c stays low while reset is asserted.
   always_ff @(posedge clk) begin
      if (capture_c) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

   assign ld_ack       = ld_ack_q;
   assign ld_count     = ld_count_q;
   assign fetch_instr  = fetch_instr_q;
   assign fetch_valid  = fetch_valid_q;
   assign fetch_loaded = fetch_loaded_q;

endmodule

// File: tb/tb_imem_load_responder.sv
// ----------------------------------------------------------------------------
// tb_imem_load_responder
//
// Directed bench for imem_load_responder. A table of one-cycle vectors covers
// capture, fetch, hold, strobe-held, rewrite and forwarding behaviour. Further
// hand-written sequences cover reset during activity and count saturation.
// ----------------------------------------------------------------------------
module tb_imem_load_responder;

   localparam int unsigned AW  = 6;
   localparam int unsigned DW  = 32;
   localparam logic [31:0] NOP = 32'h6800_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_write;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          ld_ack;
   logic [AW:0]   ld_count;
   logic          fetch_en;
   logic [AW-1:0] fetch_pc;
   logic [DW-1:0] fetch_instr;
   logic          fetch_valid;
   logic          fetch_loaded;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          fe;
      logic [AW-1:0] pc;
      logic          e_ack;
      logic [AW:0]   e_cnt;
      logic          e_fv;
      logic [DW-1:0] e_instr;
      logic          e_ld;
   } vec_t;

   vec_t vq[$];

   imem_load_responder #(.AW(AW), .DW(DW), .NOP_WORD(NOP)) dut (
      .clk          (clk),
      .reset        (reset),
      .ld_write     (ld_write),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .ld_ack       (ld_ack),
      .ld_count     (ld_count),
      .fetch_en     (fetch_en),
      .fetch_pc     (fetch_pc),
      .fetch_instr  (fetch_instr),
      .fetch_valid  (fetch_valid),
      .fetch_loaded (fetch_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_ack, input logic [AW:0] e_cnt,
                          input logic e_fv, input logic [DW-1:0] e_instr, input logic e_ld);
      chk({tag, " ld_ack"},       32'(ld_ack),       32'(e_ack));
      chk({tag, " ld_count"},     32'(ld_count),     32'(e_cnt));
      chk({tag, " fetch_valid"},  32'(fetch_valid),  32'(e_fv));
      chk({tag, " fetch_instr"},  fetch_instr,       e_instr);
      chk({tag, " fetch_loaded"}, 32'(fetch_loaded), 32'(e_ld));
   endtask

   task automatic drive(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic fe, input logic [AW-1:0] pc);
      ld_write = wr;
      ld_addr  = addr;
      ld_data  = data;
      fetch_en = fe;
      fetch_pc = pc;
   endtask

   // Advance one rising edge and then sample 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic wr, input int addr, input logic [31:0] data, input logic fe,
                      input int pc, input logic ack, input int cnt, input logic fv,
                      input logic [31:0] instr, input logic ld);
      vec_t v;
      v.wr = wr;      v.addr = AW'(addr); v.data = data;
      v.fe = fe;      v.pc = AW'(pc);
      v.e_ack = ack;  v.e_cnt = (AW+1)'(cnt); v.e_fv = fv;
      v.e_instr = instr; v.e_ld = ld;
      vq.push_back(v);
   endtask

   initial begin
      //  wr addr data          fe pc  ack cnt fv instr         ld
      add(0, 0, 32'h0,         0, 0,  0,  0,  0, NOP,          0);  // idle after release
      add(1, 0, 32'h4C40001F,  0, 0,  1,  1,  0, NOP,          0);  // capture @0
      add(0, 0, 32'h0,         1, 0,  0,  1,  1, 32'h4C40001F, 1);  // fetch pc0
      add(0, 0, 32'h0,         1, 9,  0,  1,  1, NOP,          0);  // unloaded pc9
      add(0, 0, 32'h0,         1, 0,  0,  1,  1, 32'h4C40001F, 1);
      add(0, 0, 32'h0,         0, 0,  0,  1,  0, 32'h4C40001F, 1);  // outputs hold
      add(1, 1, 32'h11111111,  0, 0,  1,  2,  0, 32'h4C40001F, 1);  // strobe held 5 cycles
      add(1, 1, 32'h11111111,  0, 0,  0,  2,  0, 32'h4C40001F, 1);
      add(1, 1, 32'h11111111,  0, 0,  0,  2,  0, 32'h4C40001F, 1);
      add(1, 1, 32'h11111111,  0, 0,  0,  2,  0, 32'h4C40001F, 1);
      add(1, 1, 32'h11111111,  0, 0,  0,  2,  0, 32'h4C40001F, 1);
      add(0, 1, 32'h0,         0, 0,  0,  2,  0, 32'h4C40001F, 1);
      add(0, 0, 32'h0,         1, 1,  0,  2,  1, 32'h11111111, 1);
      add(1, 1, 32'h4C80001D,  0, 0,  1,  2,  0, 32'h11111111, 1);  // rewrite @1
      add(0, 0, 32'h0,         1, 1,  0,  2,  1, 32'h4C80001D, 1);
      add(1, 5, 32'h10C48000,  1, 5,  1,  3,  1, 32'h10C48000, 1);  // same-cycle forward
      add(0, 0, 32'h0,         1, 5,  0,  3,  1, 32'h10C48000, 1);
      add(1, 7, 32'hAAAA5555,  1, 1,  1,  4,  1, 32'h4C80001D, 1);  // different addresses
      add(0, 0, 32'h0,         1, 7,  0,  4,  1, 32'hAAAA5555, 1);

      reset = 1'b1;
      drive(0, '0, '0, 0, '0);
      #3;
      chk_all("reset", 0, '0, 0, NOP, 0);
      step();
      step();
      chk_all("reset_held", 0, '0, 0, NOP, 0);
      reset = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].wr, vq[i].addr, vq[i].data, vq[i].fe, vq[i].pc);
         step();
         chk_all($sformatf("vec%0d", i), vq[i].e_ack, vq[i].e_cnt, vq[i].e_fv,
                 vq[i].e_instr, vq[i].e_ld);
      end

      // Load 0..8. Slots 0, 1, 5 and 7 are already loaded, so the count goes from 4 to 9.
      for (int a = 0; a < 9; a++) begin
         drive(1, AW'(a), 32'hC0DE0000 | 32'(a), 0, '0);
         step();
         drive(0, '0, '0, 0, '0);
         step();
      end
      chk("load9 ld_count", 32'(ld_count), 32'd9);
      drive(1, AW'(9), 32'hC0DE0009, 1, AW'(0));
      step();
      chk_all("pre_reset", 1, 7'd10, 1, 32'hC0DE0000, 1);

      // Assert reset mid-cycle with the strobe and the fetch still active.
      #2 reset = 1'b1;
      #1;
      chk_all("reset_async", 0, '0, 0, NOP, 0);
      step();
      step();
      chk_all("reset_mid", 0, '0, 0, NOP, 0);
      drive(1, AW'(3), 32'hDEADBEEF, 0, '0);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk_all($sformatf("strobe_at_release%0d", c), 0, '0, 0, NOP, 0);
      end
      drive(0, '0, '0, 1, AW'(0));
      step();
      chk_all("post_reset_pc0", 0, '0, 1, NOP, 0);
      drive(0, '0, '0, 1, AW'(3));
      step();
      chk_all("post_reset_pc3", 0, '0, 1, NOP, 0);
      drive(0, '0, '0, 0, '0);
      step();

      // Fill every slot twice. The count must stop at 2**AW and must not wrap.
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < 64; a++) begin
            drive(1, AW'(a), 32'h5A000000 | (32'(p) << 16) | 32'(a), 0, '0);
            step();
            chk($sformatf("fill p%0d a%0d ld_ack", p, a), 32'(ld_ack), 32'd1);
            chk($sformatf("fill p%0d a%0d ld_count", p, a), 32'(ld_count),
                (p == 0) ? 32'(a + 1) : 32'd64);
            drive(0, '0, '0, 0, '0);
            step();
         end
      end
      drive(0, '0, '0, 1, AW'(63));
      step();
      chk_all("full_pc63", 0, 7'd64, 1, 32'h5A01003F, 1);
      drive(0, '0, '0, 1, AW'(0));
      step();
      chk_all("full_pc0", 0, 7'd64, 1, 32'h5A010000, 1);
      drive(0, '0, '0, 0, '0);
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
